ifid_hazard_ctrl: RTL and testbench

Front-end pipeline controller that sequences the IF/ID register, the PC and the downstream bubble and flush controls of the 64-bit ARM pipeline.

---
 rtl/ifid_ctrl_pkg.sv | 12 +
 rtl/load_use_detect.sv | 28 ++
 rtl/ifid_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_ifid_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_ctrl_pkg.sv
// Shared types and constants for the IF/ID front-end controller.
package ifid_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } ifid_state_e;

  localparam int unsigned XZR_IDX    = 31;
  localparam int unsigned MISS_CTR_W = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that the load in EX writes.
module load_use_detect
  import ifid_ctrl_pkg::*;
#(
  parameter int unsigned RegW = 5
) (
  input  logic            id_valid_i,
  input  logic [RegW-1:0] id_rn_i,
  input  logic [RegW-1:0] id_rm_i,
  input  logic            id_uses_rm_i,
  input  logic            ex_memread_i,
  input  logic [RegW-1:0] ex_rd_i,
  output logic            load_use_o
);

  logic rd_is_xzr;
  logic rn_match;
  logic rm_match;

  always_comb begin
    // XZR is never really written, so it cannot create a dependency.
    rd_is_xzr  = (ex_rd_i == RegW'(XZR_IDX));
    rn_match   = (ex_rd_i == id_rn_i);
    rm_match   = id_uses_rm_i & (ex_rd_i == id_rm_i);
    load_use_o = id_valid_i & ex_memread_i & ~rd_is_xzr & (rn_match | rm_match);
  end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// Front-end controller: PC/IF-ID sequencing for I-cache misses, load-use stalls and branch flushes.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module ifid_hazard_ctrl
  import ifid_ctrl_pkg::*;
#(
  parameter int unsigned MISS_LAT = 4,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_hit,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             miss_busy,
  output logic [CNT_W-1:0] stall_miss_cnt,
  output logic [CNT_W-1:0] stall_lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ifid_state_e           state_q, state_d;
  logic [MISS_CTR_W-1:0] miss_ctr_q, miss_ctr_d;
  logic                  load_use;

  load_use_detect #(
    .RegW (REG_W)
  ) u_load_use_detect (
    .id_valid_i   (id_valid),
    .id_rn_i      (id_rn),
    .id_rm_i      (id_rm),
    .id_uses_rm_i (id_uses_rm),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .load_use_o   (load_use)
  );

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    miss_busy   = (state_q == MISS);
    state_d     = state_q;
    miss_ctr_d  = miss_ctr_q;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      miss_busy   = 1'b0;
      state_d     = RUN;
      miss_ctr_d  = '0;
    end else if (mem_br_taken) begin
      // Branch wins over everything and abandons any pending miss.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      miss_ctr_d  = '0;
    end else begin
      if (state_q == MISS) begin
        if (miss_ctr_q == '0) begin
          state_d = RUN;
        end else begin
          miss_ctr_d = miss_ctr_q - 1'b1;
        end
      end
      if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if ((state_q == MISS) || !if_hit) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
        if (state_q == RUN) begin
          state_d    = MISS;
          miss_ctr_d = MISS_CTR_W'(MISS_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      miss_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_ctr_q <= miss_ctr_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_miss_cnt_q, stall_miss_cnt_d;
  logic [CNT_W-1:0] stall_lu_cnt_q, stall_lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             miss_stall, lu_stall;

  always_comb begin
    miss_stall       = !mem_br_taken && ((state_q == MISS) || (!load_use && !if_hit));
    lu_stall         = !mem_br_taken && load_use;
    stall_miss_cnt_d = stall_miss_cnt_q;
    stall_lu_cnt_d   = stall_lu_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    if (miss_stall && (stall_miss_cnt_q != '1)) stall_miss_cnt_d = stall_miss_cnt_q + 1'b1;
    if (lu_stall && (stall_lu_cnt_q != '1))     stall_lu_cnt_d   = stall_lu_cnt_q + 1'b1;
    if (mem_br_taken && (flush_cnt_q != '1))    flush_cnt_d      = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_miss_cnt_q <= '0;
      stall_lu_cnt_q   <= '0;
      flush_cnt_q      <= '0;
    end else begin
      stall_miss_cnt_q <= stall_miss_cnt_d;
      stall_lu_cnt_q   <= stall_lu_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign stall_miss_cnt = stall_miss_cnt_q;
  assign stall_lu_cnt   = stall_lu_cnt_q;
  assign flush_cnt      = flush_cnt_q;
`else
  assign stall_miss_cnt = '0;
  assign stall_lu_cnt   = '0;
  assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Self-checking bench for ifid_hazard_ctrl: cycle-level model plus directed literal checks.
// Counter expectations follow HAZARD_PERF_EN (all zero when it is undefined).
module tb_ifid_hazard_ctrl;

  localparam int unsigned MissLat = 4;
  localparam int unsigned RegW    = 5;
  localparam int unsigned CntW    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_hit;
  logic            id_valid;
  logic [RegW-1:0] id_rn;
  logic [RegW-1:0] id_rm;
  logic            id_uses_rm;
  logic            ex_memread;
  logic [RegW-1:0] ex_rd;
  logic            mem_br_taken;
  logic            pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_flush;
  logic            miss_busy;
  logic [CntW-1:0] stall_miss_cnt, stall_lu_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_hazard_ctrl #(
    .MISS_LAT (MissLat),
    .REG_W    (RegW),
    .CNT_W    (CntW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_hit         (if_hit),
    .id_valid       (id_valid),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_uses_rm     (id_uses_rm),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .mem_br_taken   (mem_br_taken),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .miss_busy      (miss_busy),
    .stall_miss_cnt (stall_miss_cnt),
    .stall_lu_cnt   (stall_lu_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_flush, miss_busy}
  logic [6:0] ctrl;
  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_flush, miss_busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: number of MISS cycles still to come (0 = running normally).
  int          miss_left = 0;
  int unsigned m_miss_cnt = 0, m_lu_cnt = 0, m_flush_cnt = 0;
  bit          started = 1'b0;

  function automatic bit model_lu();
    return id_valid && ex_memread && (ex_rd != 5'd31) &&
           ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
  endfunction

  function automatic logic [6:0] model_ctrl();
    bit in_miss = (miss_left > 0);
    if (rst)                      return 7'b0110110;
    if (mem_br_taken)             return {6'b111011, in_miss};
    if (model_lu())               return {6'b000100, in_miss};
    if (in_miss || !if_hit)       return {6'b011000, in_miss};
    return 7'b1100000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      miss_left   <= 0;
      m_miss_cnt  <= 0;
      m_lu_cnt    <= 0;
      m_flush_cnt <= 0;
      started     <= 1'b1;
    end else begin
      if (mem_br_taken)                    miss_left <= 0;
      else if (miss_left > 0)              miss_left <= miss_left - 1;
      else if (!model_lu() && !if_hit)     miss_left <= MissLat;
      if (mem_br_taken) begin
        m_flush_cnt <= m_flush_cnt + 1;
      end else begin
        if (model_lu()) m_lu_cnt <= m_lu_cnt + 1;
        if ((miss_left > 0) || (!model_lu() && !if_hit)) m_miss_cnt <= m_miss_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("ctrl", 32'(ctrl), 32'(model_ctrl()));
    if (started) begin
`ifdef HAZARD_PERF_EN
      chk("stall_miss_cnt", stall_miss_cnt, m_miss_cnt);
      chk("stall_lu_cnt", stall_lu_cnt, m_lu_cnt);
      chk("flush_cnt", flush_cnt, m_flush_cnt);
`else
      chk("stall_miss_cnt", stall_miss_cnt, 0);
      chk("stall_lu_cnt", stall_lu_cnt, 0);
      chk("flush_cnt", flush_cnt, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    id_valid     = 1'b0;
    id_rn        = '0;
    id_rm        = '0;
    id_uses_rm   = 1'b0;
    ex_memread   = 1'b0;
    ex_rd        = '0;
    mem_br_taken = 1'b0;
  endtask

  int pc_low;
  int busy_cycles;

  initial begin
    rst    = 1'b1;
    if_hit = 1'b1;
    clear_hazards();

    // Reset forces the flush set regardless of inputs.
    @(negedge clk);
    chk("rst_forced", 32'(ctrl), 32'(7'b0110110));
    tick();
    tick();
    rst = 1'b0;

    // 1: idle RUN defaults
    @(negedge clk);
    chk("run_default", 32'(ctrl), 32'(7'b1100000));
    tick();

    // 2: single-cycle miss
    if_hit = 1'b0;
    pc_low = 0;
    busy_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!pc_write) pc_low++;
      if (miss_busy) busy_cycles++;
      if (i == 5) chk("miss_refetch_pc", 32'(pc_write), 1);
      tick();
      if (i == 0) if_hit = 1'b1;
    end
    chk("miss_pc_stall_cycles", pc_low, 5);
    chk("miss_busy_cycles", busy_cycles, 4);

    // 3: load-use on Rn, then XZR, then Rm with and without id_uses_rm, then invalid ID
    id_valid = 1'b1; id_rn = 5'd3; ex_memread = 1'b1; ex_rd = 5'd3;
    @(negedge clk);
    chk("lu_rn_stall", 32'(ctrl), 32'(7'b0001000));
    tick();
    ex_memread = 1'b0;
    @(negedge clk);
    chk("lu_cleared", 32'(ctrl), 32'(7'b1100000));
    tick();
    ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
    @(negedge clk);
    chk("lu_xzr_none", 32'(ctrl), 32'(7'b1100000));
    tick();
    id_rn = 5'd1; id_rm = 5'd7; id_uses_rm = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    chk("lu_rm_stall", 32'(ctrl), 32'(7'b0001000));
    tick();
    id_uses_rm = 1'b0;
    @(negedge clk);
    chk("lu_rm_unused", 32'(ctrl), 32'(7'b1100000));
    tick();
    id_valid = 1'b0; id_rn = 5'd7;
    @(negedge clk);
    chk("lu_id_invalid", 32'(ctrl), 32'(7'b1100000));
    tick();

    // 4: branch beats concurrent load-use and miss
    id_valid = 1'b1; id_rn = 5'd3; ex_rd = 5'd3; ex_memread = 1'b1;
    if_hit = 1'b0; mem_br_taken = 1'b1;
    @(negedge clk);
    chk("br_priority", 32'(ctrl), 32'(7'b1110110));
    tick();
    clear_hazards();
    if_hit = 1'b1;
    @(negedge clk);
    chk("br_stays_run", 32'(ctrl), 32'(7'b1100000));
    tick();

    // Load-use during MISS holds ID while the miss counter keeps running
    if_hit = 1'b0;
    tick();
    if_hit = 1'b1;
    id_valid = 1'b1; id_rn = 5'd4; ex_rd = 5'd4; ex_memread = 1'b1;
    @(negedge clk);
    chk("miss_lu_hold", 32'(ctrl), 32'(7'b0001001));
    tick();
    clear_hazards();
    @(negedge clk);
    chk("miss_plain", 32'(ctrl), 32'(7'b0110001));
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("miss_lu_end_run", 32'(ctrl), 32'(7'b1100000));
    tick();

    // 5: branch in the second MISS cycle
    if_hit = 1'b0;
    tick();
    if_hit = 1'b1;
    tick();
    mem_br_taken = 1'b1;
    @(negedge clk);
    chk("miss_br_flush", 32'(ctrl), 32'(7'b1110111));
    tick();
    mem_br_taken = 1'b0;
    @(negedge clk);
    chk("miss_br_after", 32'(ctrl), 32'(7'b1100000));
    tick();

    // Refetch that misses again re-enters MISS; if_hit ignored inside MISS
    if_hit = 1'b0;
    tick();
    if_hit = 1'b1;
    tick();
    tick();
    tick();
    if_hit = 1'b0;
    tick();
    @(negedge clk);
    chk("remiss_entry", 32'(ctrl), 32'(7'b0110000));
    tick();
    if_hit = 1'b1;
    @(negedge clk);
    chk("remiss_busy", 32'(ctrl), 32'(7'b0110001));
    tick();
    tick();
    tick();
    tick();

    // 6: reset in the middle of a miss
    if_hit = 1'b0;
    tick();
    if_hit = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_miss", 32'(ctrl), 32'(7'b0110110));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_back_run", 32'(ctrl), 32'(7'b1100000));
    chk("rst_miss_cnt_zero", stall_miss_cnt, 0);
    chk("rst_lu_cnt_zero", stall_lu_cnt, 0);
    chk("rst_flush_cnt_zero", flush_cnt, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
